// File: rtl/jpeg_bit_packer_pkg.sv
// rtl/jpeg_bit_packer_pkg.sv - shared JPEG packer parameters, stuffing constants and state type
package jpeg_bit_packer_pkg;

    localparam int DEF_CODE_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 6;

    // A 0xFF data byte must be followed by 0x00 so it cannot be mistaken for a marker.
    localparam logic [7:0] STUFF_TRIGGER = 8'hFF;
    localparam logic [7:0] STUFF_BYTE    = 8'h00;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STUFF = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_t;

endpackage

// File: rtl/jpeg_bit_merge.sv
// rtl/jpeg_bit_merge.sv - places len right-aligned code bits at bit position pos of an MSB-aligned word
module jpeg_bit_merge
    import jpeg_bit_packer_pkg::*;
#(
    parameter int CODE_WIDTH = DEF_CODE_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic [2*CODE_WIDTH-1:0] base,
    input  logic [CODE_WIDTH-1:0]   code,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic [LEN_WIDTH:0]      pos,
    output logic [2*CODE_WIDTH-1:0] merged
);

    localparam int ACC_W = 2 * CODE_WIDTH;
    localparam int SH_W  = LEN_WIDTH + 2;

    logic [ACC_W-1:0] len_mask;
    logic [ACC_W-1:0] code_wide;
    logic [SH_W-1:0]  shift;

    // Bits of base below pos are zero, so OR-ing the shifted code is enough.
    always_comb begin
        len_mask  = ~({ACC_W{1'b1}} << len);
        code_wide = {{CODE_WIDTH{1'b0}}, code} & len_mask;
        shift     = SH_W'(ACC_W) - SH_W'(pos) - SH_W'(len);
        merged    = base | (code_wide << shift);
    end

endmodule

// File: rtl/jpeg_bit_packer.sv
// rtl/jpeg_bit_packer.sv - packs variable-length JPEG symbols into a byte stream with 0xFF stuffing and flush
module jpeg_bit_packer
    import jpeg_bit_packer_pkg::*;
#(
    parameter int CODE_WIDTH = DEF_CODE_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CODE_WIDTH-1:0] in_code,
    input  logic [LEN_WIDTH-1:0]  in_len,
    input  logic                  in_flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  out_last,
    output logic                  done
);

    localparam int ACC_W  = 2 * CODE_WIDTH;
    localparam int FILL_W = LEN_WIDTH + 1;
    localparam logic [FILL_W-1:0] FILL_BYTE  = FILL_W'(8);
    localparam logic [FILL_W-1:0] FILL_HALF  = FILL_W'(CODE_WIDTH);
    localparam logic [FILL_W-1:0] FILL_ALIGN = ~FILL_W'(7);

    pack_state_t       state, nxt_state;
    logic [ACC_W-1:0]  acc, nxt_acc, base_acc, merged_acc, pad_mask;
    logic [FILL_W-1:0] fill, nxt_fill, base_fill, pad_fill;
    logic              flushing, nxt_flushing;
    logic              accept, emit;
    logic [7:0]        top_byte, nxt_top;

    jpeg_bit_merge #(
        .CODE_WIDTH(CODE_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_merge (
        .base  (base_acc),
        .code  (in_code),
        .len   (in_len),
        .pos   (base_fill),
        .merged(merged_acc)
    );

    always_comb begin
        accept    = in_valid && in_ready;
        emit      = out_valid && out_ready;
        top_byte  = acc[ACC_W-1 -: 8];
        base_acc  = acc;
        base_fill = fill;
        // A byte leaving in the same cycle makes room before the new code is appended.
        if (emit && state != ST_STUFF) begin
            base_acc  = acc << 8;
            base_fill = fill - FILL_BYTE;
        end
        nxt_state    = state;
        nxt_acc      = base_acc;
        nxt_fill     = base_fill;
        nxt_flushing = flushing;
        pad_fill     = '0;
        pad_mask     = '0;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    nxt_acc  = merged_acc;
                    nxt_fill = base_fill + FILL_W'(in_len);
                    if (in_flush) begin
                        pad_fill     = (nxt_fill + FILL_W'(7)) & FILL_ALIGN;
                        pad_mask     = ({ACC_W{1'b1}} >> nxt_fill) & ~({ACC_W{1'b1}} >> pad_fill);
                        nxt_acc      = merged_acc | pad_mask;
                        nxt_fill     = pad_fill;
                        nxt_flushing = 1'b1;
                        nxt_state    = ST_FLUSH;
                    end
                end
                if (emit && top_byte == STUFF_TRIGGER) nxt_state = ST_STUFF;
            end
            ST_FLUSH: begin
                if (emit) begin
                    if (top_byte == STUFF_TRIGGER) nxt_state = ST_STUFF;
                    else if (out_last)             nxt_state = ST_DONE;
                end else if (fill == '0) begin
                    nxt_state = ST_DONE;
                end
            end
            ST_STUFF: begin
                if (emit) begin
                    if (!flushing)        nxt_state = ST_RUN;
                    else if (fill == '0)  nxt_state = ST_DONE;
                    else                  nxt_state = ST_FLUSH;
                end
            end
            ST_DONE: begin
                nxt_state    = ST_RUN;
                nxt_acc      = '0;
                nxt_fill     = '0;
                nxt_flushing = 1'b0;
            end
            default: nxt_state = ST_RUN;
        endcase
        nxt_top = nxt_acc[ACC_W-1 -: 8];
    end

    // Outputs are registered from the next-state values so they line up with state/fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            acc       <= '0;
            fill      <= '0;
            flushing  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            acc       <= nxt_acc;
            fill      <= nxt_fill;
            flushing  <= nxt_flushing;
            in_ready  <= (nxt_state == ST_RUN) && (nxt_fill <= FILL_HALF);
            out_valid <= (nxt_state == ST_STUFF) ||
                         ((nxt_state == ST_RUN || nxt_state == ST_FLUSH) && nxt_fill >= FILL_BYTE);
            out_byte  <= (nxt_state == ST_STUFF) ? STUFF_BYTE : nxt_top;
            out_last  <= (nxt_state == ST_FLUSH && nxt_fill == FILL_BYTE && nxt_top != STUFF_TRIGGER) ||
                         (nxt_state == ST_STUFF && nxt_flushing && nxt_fill == '0);
            done      <= (nxt_state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb/tb_jpeg_bit_packer.sv - directed and randomized bench for jpeg_bit_packer against a bit-queue model
module tb_jpeg_bit_packer;

    localparam int CW = 32;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_flush;
    logic [CW-1:0] in_code;
    logic [LW-1:0] in_len;
    logic          out_valid, out_ready, out_last, done;
    logic [7:0]    out_byte;

    int   checks = 0;
    int   errors = 0;
    int   ready_pct = 0;
    bit   hold_low = 1'b0;
    bit   in_stuff = 1'b0;
    bit   bitq[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    jpeg_bit_packer #(.CODE_WIDTH(CW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .in_len(in_len), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_last(out_last), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stream model: bits in MSB-first order, bytes formed eight at a time, 0x00 after each 0xFF.
    task automatic model_pack();
        logic [7:0] b;
        while (bitq.size() >= 8) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) b = {b[6:0], bitq.pop_front()};
            exp_q.push_back({1'b0, b});
            if (b == 8'hFF) exp_q.push_back(9'h000);
        end
    endtask

    task automatic model_push(input logic [31:0] code, input int len);
        for (int i = len - 1; i >= 0; i--) bitq.push_back(code[i]);
        model_pack();
    endtask

    task automatic model_flush();
        logic [8:0] tail;
        while (bitq.size() % 8 != 0) bitq.push_back(1'b1);
        model_pack();
        if (exp_q.size() != 0) begin
            tail = exp_q.pop_back();
            tail[8] = 1'b1;
            exp_q.push_back(tail);
        end
    endtask

    always @(posedge clk) begin
        #2;
        out_ready = hold_low ? 1'b0 : ($urandom_range(99) < ready_pct);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (in_stuff) chk("in_ready_low_in_stuff", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_byte observed 0x%02h expected no byte", out_byte);
                end
                if (exp_q.size() != 0) chk("out_last_byte", {23'd0, out_last, out_byte}, {23'd0, exp_q.pop_front()});
                in_stuff = (out_byte == 8'hFF);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] code, input int len, input bit flush);
        int n = 0;
        while (!in_ready && n < 2000) begin
            step();
            n++;
        end
        chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        if (flush) begin
            hold_low  = 1'b1;
            out_ready = 1'b0;
        end
        in_valid = 1'b1;
        in_code  = code;
        in_len   = len[LW-1:0];
        in_flush = flush;
        step();
        model_push(code, len);
        if (flush) model_flush();
        in_valid = 1'b0;
        in_flush = 1'b0;
        hold_low = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            step();
            n++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, {31'd0, n <= max_cyc}, 32'd1);
        step();
        chk({tag, "_done_single"}, {31'd0, done}, 32'd0);
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] code;
        rst = 1'b1; in_valid = 1'b0; in_code = '0; in_len = '0; in_flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_byte",  {24'd0, out_byte},  32'd0);
        rst = 1'b0;
        step();
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        ready_pct = 100;
        send(32'b1010, 4, 1'b0);
        send(32'b1100, 4, 1'b0);
        repeat (5) step();
        chk("pair_0xAC_drained", exp_q.size(), 32'd0);

        send(32'hFF, 8, 1'b0);
        repeat (6) step();
        chk("ff_stuff_drained", exp_q.size(), 32'd0);

        send(32'b101, 3, 1'b1);
        wait_done(3000, "flush_bf");

        send(32'h0, 0, 1'b1);
        wait_done(2, "flush_empty");

        send(32'h12FF, 16, 1'b1);
        wait_done(3000, "flush_ff_last");

        ready_pct = 0;
        repeat (2) step();
        send(32'h12345678, 32, 1'b0);
        send(32'h12345678, 32, 1'b0);
        chk("in_ready_full", {31'd0, in_ready}, 32'd0);
        repeat (10) step();
        chk("in_ready_full_held", {31'd0, in_ready}, 32'd0);
        ready_pct = 100;
        send(32'h12345678, 32, 1'b0);
        send(32'h12345678, 32, 1'b0);
        repeat (20) step();
        chk("backpressure_drained", exp_q.size(), 32'd0);

        send(32'b10101, 5, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bitq.delete();
        in_stuff = 1'b0;
        chk("in_ready_low_after_rst", {31'd0, in_ready}, 32'd0);
        step();
        chk("in_ready_rise_after_rst", {31'd0, in_ready}, 32'd1);
        repeat (4) begin
            step();
            chk("no_byte_after_rst", {31'd0, out_valid}, 32'd0);
        end
        send(32'hAB, 8, 1'b0);
        repeat (4) step();
        chk("post_rst_0xAB_drained", exp_q.size(), 32'd0);

        for (int s = 0; s < 3; s++) begin
            ready_pct = 40 + 20 * s;
            for (int i = 0; i < 30; i++) begin
                code = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
                send(code, $urandom_range(32, 0), 1'b0);
            end
            send($urandom, $urandom_range(32, 0), 1'b1);
            wait_done(3000, "rand_scan");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
